// File: rtl/dualram_pkg.sv
// Shared types and constants for the synchronous dual-port RAM.
// Imported by the interface, read pipeline and top level.
package dualram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RD_LAT_1 = 1;
    localparam int RD_LAT_2 = 2;

    localparam int BYPASS_READ_OLD = 0;
    localparam int BYPASS_READ_NEW = 1;

endpackage

// File: rtl/sync_dualram_param_if.sv
// Request/response bundle of the dual-port RAM.
// The master drives requests; the slave (RAM) returns read data and status.
interface sync_dualram_param_if
    import dualram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  i_cs;
    logic                  i_wr_enb;
    logic [ADDR_WIDTH-1:0] i_wr_addr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_rd_enb;
    logic [ADDR_WIDTH-1:0] i_rd_addr;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_busy;

    modport master (
        output i_cs, i_wr_enb, i_wr_addr, i_wr_data,
        output i_rd_enb, i_rd_addr,
        input  o_rd_data, o_rd_valid, o_busy
    );

    modport slave (
        input  i_cs, i_wr_enb, i_wr_addr, i_wr_data,
        input  i_rd_enb, i_rd_addr,
        output o_rd_data, o_rd_valid, o_busy
    );

endinterface

// File: rtl/dualram_rd_pipe.sv
// Read result pipeline of 1 or 2 stages.
// Each stage only loads on a valid result, so the output holds between reads.
module dualram_rd_pipe
    import dualram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_data [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            if (i_valid) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid = r_valid[RD_LATENCY-1];
    assign o_data  = r_data[RD_LATENCY-1];

endmodule

// File: rtl/sync_dualram_param.sv
// Simple dual-port RAM with post-reset clear sequencer, range checks,
// selectable collision behaviour and 1/2-cycle read latency.
module sync_dualram_param
    import dualram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int RD_LATENCY = 1,
    parameter int BYPASS     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    sync_dualram_param_if.slave  if_bus
);

    if (RD_LATENCY != RD_LAT_1 && RD_LATENCY != RD_LAT_2) begin : g_bad_lat
        $error("RD_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("DEPTH must be in 1 .. 2**ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH-1:0] w_clr_ptr_nxt;
    logic                  r_busy;
    logic                  w_clr_we;
    logic                  w_run;
    logic                  w_wr_ok;
    logic                  w_rd_req;
    logic                  w_rd_in_rng;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rd_word;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_clr_we      = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_ptr == LAST_ADDR) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_busy    <= (w_state_nxt == ST_CLEAR);
        end
    end

    assign w_run       = (r_state == ST_RUN);
    assign w_wr_ok     = w_run && if_bus.i_cs && if_bus.i_wr_enb
                         && ({1'b0, if_bus.i_wr_addr} < DEPTH_W);
    assign w_rd_req    = w_run && if_bus.i_cs && if_bus.i_rd_enb;
    assign w_rd_in_rng = {1'b0, if_bus.i_rd_addr} < DEPTH_W;
    assign w_collide   = w_wr_ok && (if_bus.i_wr_addr == if_bus.i_rd_addr);

    // Read-new forwards the incoming word; read-old sees the array before the edge.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_rng) begin
            if (BYPASS == BYPASS_READ_NEW && w_collide) begin
                w_rd_word = if_bus.i_wr_data;
            end else begin
                w_rd_word = r_mem[if_bus.i_rd_addr];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_wr_ok) begin
                r_mem[if_bus.i_wr_addr] <= if_bus.i_wr_data;
            end
        end
    end

    dualram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (w_rd_req),
        .i_data  (w_rd_word),
        .o_valid (if_bus.o_rd_valid),
        .o_data  (if_bus.o_rd_data)
    );

    assign if_bus.o_busy = r_busy;

endmodule

// File: tb/tb_sync_dualram_param.sv
// Bench for sync_dualram_param: three configurations share one stimulus
// stream and are checked every cycle against a behavioural model.
module tb_sync_dualram_param;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NI = 3;

    // instance 0: depth 16, latency 1, read-old
    // instance 1: depth 16, latency 2, read-new
    // instance 2: depth 12, latency 1, read-old
    function automatic int dep(int k);
        return (k == 2) ? 12 : 16;
    endfunction
    function automatic int lat(int k);
        return (k == 1) ? 2 : 1;
    endfunction
    function automatic bit byp(int k);
        return (k == 1);
    endfunction

    logic          clk = 1'b0;
    logic          rst;
    logic          cs, we, re;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;

    always #5 clk = ~clk;

    sync_dualram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
    sync_dualram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();
    sync_dualram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_c ();

    assign if_a.i_cs = cs;  assign if_a.i_wr_enb = we;  assign if_a.i_rd_enb = re;
    assign if_a.i_wr_addr = wa;  assign if_a.i_wr_data = wd;  assign if_a.i_rd_addr = ra;
    assign if_b.i_cs = cs;  assign if_b.i_wr_enb = we;  assign if_b.i_rd_enb = re;
    assign if_b.i_wr_addr = wa;  assign if_b.i_wr_data = wd;  assign if_b.i_rd_addr = ra;
    assign if_c.i_cs = cs;  assign if_c.i_wr_enb = we;  assign if_c.i_rd_enb = re;
    assign if_c.i_wr_addr = wa;  assign if_c.i_wr_data = wd;  assign if_c.i_rd_addr = ra;

    sync_dualram_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16), .RD_LATENCY(1), .BYPASS(0)
    ) u_a (.i_clk(clk), .i_rst(rst), .if_bus(if_a.slave));

    sync_dualram_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16), .RD_LATENCY(2), .BYPASS(1)
    ) u_b (.i_clk(clk), .i_rst(rst), .if_bus(if_b.slave));

    sync_dualram_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(12), .RD_LATENCY(1), .BYPASS(0)
    ) u_c (.i_clk(clk), .i_rst(rst), .if_bus(if_c.slave));

    logic [DW-1:0] d_data  [NI];
    logic          d_valid [NI];
    logic          d_busy  [NI];

    assign d_data[0] = if_a.o_rd_data;  assign d_valid[0] = if_a.o_rd_valid;  assign d_busy[0] = if_a.o_busy;
    assign d_data[1] = if_b.o_rd_data;  assign d_valid[1] = if_b.o_rd_valid;  assign d_busy[1] = if_b.o_busy;
    assign d_data[2] = if_c.o_rd_data;  assign d_valid[2] = if_c.o_rd_valid;  assign d_busy[2] = if_c.o_busy;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Model: memory contents, clear countdown and results scheduled by due edge.
    logic [DW-1:0] mem   [NI][16];
    logic [DW-1:0] sch_d [NI][4];
    logic          sch_v [NI][4];
    logic          m_busy [NI];
    logic          m_v    [NI];
    logic [DW-1:0] m_d    [NI];
    int            m_cnt  [NI];
    int            ecnt = 0;
    bit            m_init = 0;

    initial begin
        int s;
        logic [DW-1:0] val;
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (rst) begin
                    m_busy[k] = 1'b1;
                    m_cnt[k]  = 0;
                    m_v[k]    = 1'b0;
                    m_d[k]    = '0;
                    for (int j = 0; j < 4; j++) sch_v[k][j] = 1'b0;
                    for (int a = 0; a < 16; a++) mem[k][a] = '0;
                end else if (m_busy[k]) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == dep(k)) m_busy[k] = 1'b0;
                    m_v[k] = 1'b0;
                end else begin
                    if (cs && re) begin
                        if (int'(ra) >= dep(k))
                            val = '0;
                        else if (byp(k) && we && wa == ra)
                            val = wd;
                        else
                            val = mem[k][ra];
                        s = (ecnt + lat(k) - 1) % 4;
                        sch_v[k][s] = 1'b1;
                        sch_d[k][s] = val;
                    end
                    if (cs && we && int'(wa) < dep(k)) mem[k][wa] = wd;
                    s = ecnt % 4;
                    if (sch_v[k][s]) begin
                        m_v[k] = 1'b1;
                        m_d[k] = sch_d[k][s];
                        sch_v[k][s] = 1'b0;
                    end else begin
                        m_v[k] = 1'b0;
                    end
                end
            end
            if (rst) m_init = 1;
            ecnt++;
        end
    end

    int            nv [NI] = '{0, 0, 0};
    logic [DW-1:0] qb [$];

    initial forever begin
        @(negedge clk);
        if (m_init) begin
            for (int k = 0; k < NI; k++) begin
                chk("busy", k, 32'(d_busy[k]), 32'(m_busy[k]));
                chk("rd_valid", k, 32'(d_valid[k]), 32'(m_v[k]));
                chk("rd_data", k, 32'(d_data[k]), 32'(m_d[k]));
            end
        end
        for (int k = 0; k < NI; k++) begin
            if (d_valid[k] === 1'b1) begin
                nv[k]++;
                if (k == 1) qb.push_back(d_data[1]);
            end
        end
    end

    task automatic req(bit c, bit w, int aw_i, int dw_i, bit r, int ar_i);
        cs = c;
        we = w;
        wa = AW'(aw_i);
        wd = DW'(dw_i);
        re = r;
        ra = AW'(ar_i);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) req(0, 0, 0, 0, 0, 0);
    endtask

    int nb [NI];
    int v0 [NI];

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) req(1, 1, 0, 'hFF, 1, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;

        nb = '{0, 0, 0};
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < NI; k++) if (d_busy[k]) nb[k]++;
            if (i < 10) req(1, 1, 0, 'hFF, 1, 0);
            else idle(1);
        end
        chk("busy_len", 0, nb[0], 16);
        chk("busy_len", 1, nb[1], 16);
        chk("busy_len", 2, nb[2], 12);

        v0 = nv;
        for (int a = 0; a < 16; a++) req(1, 0, 0, 0, 1, a);
        idle(3);
        for (int k = 0; k < NI; k++) begin
            chk("clear_reads", k, nv[k] - v0[k], 16);
            chk("clear_data", k, 32'(d_data[k]), 0);
        end

        req(1, 1, 3, 'hA5, 0, 0);
        req(1, 0, 0, 0, 1, 3);
        chk("a5_data", 0, 32'(d_data[0]), 'hA5);
        chk("a5_valid", 0, 32'(d_valid[0]), 1);
        idle(1);
        chk("a5_hold", 0, 32'(d_data[0]), 'hA5);
        chk("a5_low", 0, 32'(d_valid[0]), 0);
        idle(2);

        for (int i = 0; i < 16; i++) req(1, 1, i, 'h10 + i, 0, 0);
        qb.delete();
        for (int i = 0; i < 16; i++) req(1, 0, 0, 0, 1, i);
        idle(3);
        chk("stream_count", 1, qb.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < qb.size()) chk("stream_val", 1, 32'(qb[i]), 'h10 + i);
        end

        req(1, 1, 5, 'h11, 0, 0);
        idle(1);
        req(1, 1, 5, 'h22, 1, 5);
        idle(3);
        chk("collide", 0, 32'(d_data[0]), 'h11);
        chk("collide", 1, 32'(d_data[1]), 'h22);
        chk("collide", 2, 32'(d_data[2]), 'h11);
        req(1, 0, 0, 0, 1, 5);
        idle(3);
        for (int k = 0; k < NI; k++) chk("after_collide", k, 32'(d_data[k]), 'h22);

        v0 = nv;
        repeat (3) req(0, 1, 5, 'h99, 1, 5);
        idle(2);
        for (int k = 0; k < NI; k++) chk("cs_low_valid", k, nv[k] - v0[k], 0);
        req(1, 0, 0, 0, 1, 5);
        idle(3);
        for (int k = 0; k < NI; k++) chk("cs_low_nowrite", k, 32'(d_data[k]), 'h22);

        v0 = nv;
        req(1, 1, 13, 'h77, 0, 0);
        req(1, 0, 0, 0, 1, 13);
        idle(3);
        chk("oor_data", 2, 32'(d_data[2]), 0);
        chk("oor_valid", 2, nv[2] - v0[2], 1);
        chk("inrange13", 0, 32'(d_data[0]), 'h77);
        for (int a = 0; a < 12; a++) req(1, 0, 0, 0, 1, a);
        idle(3);
        chk("last_word", 2, 32'(d_data[2]), 'h1B);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
